// File: rtl/video_move_pkg.sv
// Shared types and helpers for the moving-window position sequencer.
// Imported by video_move_ctrl and available to the splicer timing blocks.
package video_move_pkg;

  localparam int POS_W_DEF = 12;
  localparam int DIV_W     = 8;

  typedef enum logic {
    HOME = 1'b0,
    RUN  = 1'b1
  } move_state_e;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } move_dir_e;

  // Largest legal offset of a window inside the active area; an oversized window pins it to 0.
  function automatic int unsigned calc_max(input int unsigned active, input int unsigned win);
    return (win >= active) ? 32'd0 : (active - win);
  endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Registered rising-edge detector for a level that is already synchronous to clk.
// The pulse is combinational in the cycle the level first reads high.
module vsync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/video_move_ctrl.sv
// Per-frame X/Y offset sequencer that bounces the splicer's moving window inside the active area.
// Offsets only change on a frame boundary so the splicer never sees a mid-frame position change.
module video_move_ctrl
  import video_move_pkg::*;
#(
  parameter int H_ACTIVE  = 1920,
  parameter int V_ACTIVE  = 1080,
  parameter int WIN_W     = 960,
  parameter int WIN_H     = 540,
  parameter int STEP_X    = 4,
  parameter int STEP_Y    = 2,
  parameter int FRAME_DIV = 1,
  parameter int POS_W     = POS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             I_video_move_en,
  input  logic             I_vsync,
  output logic [POS_W-1:0] O_x_offset,
  output logic [POS_W-1:0] O_y_offset,
  output logic             O_pos_update,
  output logic             O_moving
);

  localparam int unsigned X_MAX = calc_max(H_ACTIVE, WIN_W);
  localparam int unsigned Y_MAX = calc_max(V_ACTIVE, WIN_H);

  // One extra bit of headroom so pos + step can never wrap before the clamp compare.
  localparam logic [POS_W:0] XMAX_E  = (POS_W+1)'(X_MAX);
  localparam logic [POS_W:0] YMAX_E  = (POS_W+1)'(Y_MAX);
  localparam logic [POS_W:0] STEPX_E = (POS_W+1)'(STEP_X);
  localparam logic [POS_W:0] STEPY_E = (POS_W+1)'(STEP_Y);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  move_state_e      state_q, state_d;
  move_dir_e        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  move_dir_e        dir_x_step, dir_y_step;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic [POS_W-1:0] x_step, y_step;
  logic [DIV_W-1:0] div_q, div_d;
  logic             upd_q, upd_d;
  logic             moving;
  logic             frame_start;

  vsync_edge_det u_vsync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (I_vsync),
    .rise_o (frame_start)
  );

  // One bounce step along a single axis; a zero-sized travel range holds position and direction.
  function automatic void step_axis(
    input  logic [POS_W-1:0] pos,
    input  move_dir_e        dir,
    input  logic [POS_W:0]   max_e,
    input  logic [POS_W:0]   step_e,
    output logic [POS_W-1:0] pos_n,
    output move_dir_e        dir_n
  );
    logic [POS_W:0] ext;
    logic [POS_W:0] sum;
    ext   = {1'b0, pos};
    sum   = ext + step_e;
    pos_n = pos;
    dir_n = dir;
    if (max_e == '0) begin
      pos_n = '0;
    end else if (dir == DIR_POS) begin
      if (sum >= max_e) begin
        pos_n = POS_W'(max_e);
        dir_n = DIR_NEG;
      end else begin
        pos_n = POS_W'(sum);
      end
    end else begin
      if (ext <= step_e) begin
        pos_n = '0;
        dir_n = DIR_POS;
      end else begin
        pos_n = POS_W'(ext - step_e);
      end
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOME;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      case (state_q)
        HOME: if (I_video_move_en)  state_d = RUN;
        RUN:  if (!I_video_move_en) state_d = HOME;
        default: state_d = HOME;
      endcase
    end
  end

  // Enable is only looked at on frame_start, so mid-frame toggles are invisible here.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    div_d   = div_q;
    upd_d   = 1'b0;
    moving  = (state_q == RUN);
    step_axis(x_q, dir_x_q, XMAX_E, STEPX_E, x_step, dir_x_step);
    step_axis(y_q, dir_y_q, YMAX_E, STEPY_E, y_step, dir_y_step);
    if (frame_start) begin
      case (state_q)
        HOME: begin
          div_d = '0;
          if (!I_video_move_en) begin
            x_d     = '0;
            y_d     = '0;
            dir_x_d = DIR_POS;
            dir_y_d = DIR_POS;
            upd_d   = 1'b1;
          end
        end
        RUN: begin
          if (!I_video_move_en) begin
            x_d     = '0;
            y_d     = '0;
            dir_x_d = DIR_POS;
            dir_y_d = DIR_POS;
            div_d   = '0;
            upd_d   = 1'b1;
          end else if (div_q == DIV_LAST) begin
            x_d     = x_step;
            y_d     = y_step;
            dir_x_d = dir_x_step;
            dir_y_d = dir_y_step;
            div_d   = '0;
            upd_d   = 1'b1;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: begin
          div_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      dir_x_q <= DIR_POS;
      dir_y_q <= DIR_POS;
      div_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      div_q   <= div_d;
      upd_q   <= upd_d;
    end
  end

  assign O_x_offset   = x_q;
  assign O_y_offset   = y_q;
  assign O_pos_update = upd_q;
  assign O_moving     = moving;

endmodule

// File: tb/tb_video_move_ctrl.sv
// Directed bench for video_move_ctrl: defaults, a divided-rate copy and a non-multiple-step copy
// share one stimulus stream; expected values are worked out by hand from the movement rules.
module tb_video_move_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        vsync;
  logic [11:0] xA, yA, xB, yB, xC, yC;
  logic        updA, movA, updB, movB, updC, movC;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  video_move_ctrl u_dutA (
    .clk (clk), .rst_n (rst_n), .I_video_move_en (en), .I_vsync (vsync),
    .O_x_offset (xA), .O_y_offset (yA), .O_pos_update (updA), .O_moving (movA)
  );

  video_move_ctrl #(.FRAME_DIV (3)) u_dutB (
    .clk (clk), .rst_n (rst_n), .I_video_move_en (en), .I_vsync (vsync),
    .O_x_offset (xB), .O_y_offset (yB), .O_pos_update (updB), .O_moving (movB)
  );

  // Step 7 never lands exactly on X_MAX=960; a full-height window pins Y_MAX to 0.
  video_move_ctrl #(.STEP_X (7), .WIN_H (1080)) u_dutC (
    .clk (clk), .rst_n (rst_n), .I_video_move_en (en), .I_vsync (vsync),
    .O_x_offset (xC), .O_y_offset (yC), .O_pos_update (updC), .O_moving (movC)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Raise vsync and return once the frame-start update is visible on the outputs.
  task automatic applyStimulus(input logic enable);
    en    = enable;
    vsync = 1'b1;
    tick();
  endtask

  // Holding vsync high for another cycle must not retrigger; then drop it for the rest of the frame.
  task automatic finishFrame(input string tag);
    tick();
    checkOutput({tag, "_upd_held"}, {31'd0, updA}, 32'd0);
    vsync = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    vsync = 1'b0;
    repeat (2) tick();
    checkOutput("rst_x", {20'd0, xA}, 32'd0);
    checkOutput("rst_y", {20'd0, yA}, 32'd0);
    checkOutput("rst_upd", {31'd0, updA}, 32'd0);
    checkOutput("rst_moving", {31'd0, movA}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("idle_upd", {31'd0, updA}, 32'd0);

    for (int f = 0; f < 3; f++) begin
      applyStimulus(1'b0);
      checkOutput("home_upd", {31'd0, updA}, 32'd1);
      checkOutput("home_x", {20'd0, xA}, 32'd0);
      checkOutput("home_y", {20'd0, yA}, 32'd0);
      checkOutput("home_moving", {31'd0, movA}, 32'd0);
      finishFrame("home");
    end

    applyStimulus(1'b1);
    checkOutput("entry_upd", {31'd0, updA}, 32'd0);
    checkOutput("entry_x", {20'd0, xA}, 32'd0);
    checkOutput("entry_moving", {31'd0, movA}, 32'd1);
    checkOutput("entry_updB", {31'd0, updB}, 32'd0);
    checkOutput("entry_movingC", {31'd0, movC}, 32'd1);
    finishFrame("entry");

    for (int k = 1; k <= 241; k++) begin
      applyStimulus(1'b1);
      if (k <= 10) begin
        checkOutput("run_x", {20'd0, xA}, 32'(4 * k));
        checkOutput("run_y", {20'd0, yA}, 32'(2 * k));
        checkOutput("run_upd", {31'd0, updA}, 32'd1);
        checkOutput("div3_x", {20'd0, xB}, 32'(4 * (k / 3)));
        checkOutput("div3_y", {20'd0, yB}, 32'(2 * (k / 3)));
        checkOutput("div3_upd", {31'd0, updB}, (k % 3 == 0) ? 32'd1 : 32'd0);
        checkOutput("step7_x", {20'd0, xC}, 32'(7 * k));
        checkOutput("step7_y", {20'd0, yC}, 32'd0);
      end
      if (k == 10) checkOutput("frame11_moving", {31'd0, movA}, 32'd1);
      if (k == 137) checkOutput("step7_below_max", {20'd0, xC}, 32'd959);
      if (k == 138) checkOutput("step7_clamp", {20'd0, xC}, 32'd960);
      if (k == 139) checkOutput("step7_back", {20'd0, xC}, 32'd953);
      if (k == 240) begin
        checkOutput("bounce_clamp_x", {20'd0, xA}, 32'd960);
        checkOutput("bounce_y", {20'd0, yA}, 32'd480);
      end
      if (k == 241) begin
        checkOutput("bounce_back_x", {20'd0, xA}, 32'd956);
        checkOutput("bounce_back_y", {20'd0, yA}, 32'd482);
        checkOutput("div3_late_x", {20'd0, xB}, 32'd320);
        checkOutput("div3_late_y", {20'd0, yB}, 32'd160);
        checkOutput("step7_late_y", {20'd0, yC}, 32'd0);
      end
      finishFrame("run");
    end

    en = 1'b0;
    repeat (3) tick();
    checkOutput("glitch_hold_x", {20'd0, xA}, 32'd956);
    checkOutput("glitch_moving", {31'd0, movA}, 32'd1);
    en = 1'b1;
    tick();
    applyStimulus(1'b1);
    checkOutput("glitch_ignored_x", {20'd0, xA}, 32'd952);
    checkOutput("glitch_ignored_y", {20'd0, yA}, 32'd484);
    finishFrame("glitch");

    en = 1'b0;
    repeat (3) tick();
    checkOutput("stop_wait_x", {20'd0, xA}, 32'd952);
    checkOutput("stop_wait_upd", {31'd0, updA}, 32'd0);
    checkOutput("stop_wait_moving", {31'd0, movA}, 32'd1);
    applyStimulus(1'b0);
    checkOutput("stop_x", {20'd0, xA}, 32'd0);
    checkOutput("stop_y", {20'd0, yA}, 32'd0);
    checkOutput("stop_upd", {31'd0, updA}, 32'd1);
    checkOutput("stop_moving", {31'd0, movA}, 32'd0);
    finishFrame("stop");

    // Re-entry must move +X again: a stale negative direction would pin x at 0 instead of 4.
    applyStimulus(1'b1);
    checkOutput("reentry_upd", {31'd0, updA}, 32'd0);
    checkOutput("reentry_moving", {31'd0, movA}, 32'd1);
    finishFrame("reentry");
    applyStimulus(1'b1);
    checkOutput("reentry_dir_x", {20'd0, xA}, 32'd4);
    checkOutput("reentry_dir_y", {20'd0, yA}, 32'd2);
    finishFrame("reentry_step");
    for (int k = 0; k < 24; k++) begin
      applyStimulus(1'b1);
      finishFrame("climb");
    end
    checkOutput("prereset_x", {20'd0, xA}, 32'd100);
    checkOutput("prereset_y", {20'd0, yA}, 32'd50);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_x", {20'd0, xA}, 32'd0);
    checkOutput("async_rst_y", {20'd0, yA}, 32'd0);
    checkOutput("async_rst_moving", {31'd0, movA}, 32'd0);
    checkOutput("async_rst_upd", {31'd0, updA}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("post_rst_x", {20'd0, xA}, 32'd0);
    checkOutput("post_rst_upd", {31'd0, updA}, 32'd0);
    checkOutput("post_rst_moving", {31'd0, movA}, 32'd0);
    applyStimulus(1'b1);
    checkOutput("post_rst_entry_upd", {31'd0, updA}, 32'd0);
    checkOutput("post_rst_entry_moving", {31'd0, movA}, 32'd1);
    finishFrame("post_rst_entry");
    applyStimulus(1'b1);
    checkOutput("post_rst_step_x", {20'd0, xA}, 32'd4);
    checkOutput("post_rst_step_upd", {31'd0, updA}, 32'd1);
    finishFrame("post_rst_step");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
